// File: rtl/asr_return.sv
// Response-return path: records granted requester ids in order and routes in-order responses back
// through a single holding register. Optional watchdog on the head tag under `ASR_TIMEOUT_EN.
module asr_return #(
    parameter int unsigned switch_bits    = 3,
    parameter int unsigned data_width     = 132,
    parameter int unsigned tag_depth      = 4,
    parameter int unsigned timeout_cycles = 255
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           grant_valid,
    input  logic [switch_bits-1:0]         grant_id,
    output logic                           tag_full,
    input  logic                           rsp_valid,
    input  logic [data_width-1:0]          rsp_data,
    output logic                           rsp_ready,
    output logic [(1<<switch_bits)-1:0]    out_valid,
    output logic [data_width-1:0]          out_data,
    input  logic [(1<<switch_bits)-1:0]    out_ready,
    output logic [$clog2(tag_depth):0]     outstanding,
    output logic                           orphan_err,
    output logic                           drop_err,
    output logic                           timeout_err
);

    localparam int unsigned N  = 1 << switch_bits;
    localparam int unsigned PW = $clog2(tag_depth);
    localparam int unsigned CW = PW + 1;

    logic [switch_bits-1:0] tags [tag_depth];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [CW-1:0]          count;

    logic                   hold_v;
    logic [switch_bits-1:0] hold_id;
    logic [data_width-1:0]  hold_data;

    logic                   free;
    logic                   push;
    logic                   pop;
    logic                   accept;
    logic                   wd_hit;
    logic                   not_empty;

    assign not_empty = (count != '0);
    assign tag_full  = (count == CW'(tag_depth));
    assign free      = !hold_v || out_ready[hold_id];
    assign rsp_ready = not_empty && free && !wd_hit;
    assign accept    = rsp_valid && rsp_ready;
    assign push      = grant_valid && !tag_full;
    assign pop       = accept || wd_hit;

    assign out_valid   = hold_v ? (N'(1) << hold_id) : '0;
    assign out_data    = hold_data;
    assign outstanding = count + CW'(hold_v);

    // Tag storage needs no reset: entries are only read below count.
    always_ff @(posedge clk) begin
        if (push) begin
            tags[wr_ptr] <= grant_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Holding register: load on accept, drain once the target has taken it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_v    <= 1'b0;
            hold_id   <= '0;
            hold_data <= '0;
        end else if (accept) begin
            hold_v    <= 1'b1;
            hold_id   <= tags[rd_ptr];
            hold_data <= rsp_data;
        end else if (free) begin
            hold_v    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            orphan_err <= 1'b0;
            drop_err   <= 1'b0;
        end else begin
            if (rsp_valid && !not_empty) begin
                orphan_err <= 1'b1;
            end
            if (grant_valid && tag_full) begin
                drop_err <= 1'b1;
            end
        end
    end

`ifdef ASR_TIMEOUT_EN
    localparam int unsigned WW = $clog2(timeout_cycles + 1);

    logic [WW-1:0] wd_cnt;
    logic          timeout_q;

    // Head tag has waited timeout_cycles cycles: retire it without delivery.
    assign wd_hit      = not_empty && (wd_cnt == WW'(timeout_cycles - 1));
    assign timeout_err = timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (!not_empty || pop) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + WW'(1);
            end
            if (wd_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout;

    assign wd_hit         = 1'b0;
    assign timeout_err    = 1'b0;
    assign unused_timeout = ^(32'(timeout_cycles));
`endif

endmodule
